// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state type, defaults and width helper for bus_arbiter
//
// Purpose: common definitions imported by bus_arbiter and rr_pick.
// Ports:   none (package).

package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE,
    ST_GAP
  } arb_state_e;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_CPU_GAP = 2;

  // Wide enough for CPU_GAP up to 15.
  localparam int GAP_CNT_W = 4;

  // Width of the owner index; never below one bit.
  function automatic int owner_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin winner selection
//
// Purpose: pick the first active requester strictly after last_i, wrapping
//          N_REQ-1 -> 0; last_i itself is considered last.
// Ports:
//   req_i   in   N_REQ        active-high request vector
//   last_i  in   owner width  index the search starts after
//   valid_o out  1            at least one request is active
//   idx_o   out  owner width  winning index (0 when valid_o is low)

module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]          req_i,
  input  logic [owner_w(N_REQ)-1:0] last_i,
  output logic                      valid_o,
  output logic [owner_w(N_REQ)-1:0] idx_o
);

  localparam int OW = owner_w(N_REQ);

  // Each candidate gets its distance from last_i+1 around the ring; the
  // nearest active one wins.
  always_comb begin : pick
    int best_dist;
    int cand_dist;
    valid_o   = 1'b0;
    idx_o     = '0;
    best_dist = N_REQ;
    cand_dist = 0;
    for (int j = 0; j < N_REQ; j++) begin
      cand_dist = (j + 2 * N_REQ - int'(last_i) - 1) % N_REQ;
      if (req_i[j] && (cand_dist < best_dist)) begin
        best_dist = cand_dist;
        valid_o   = 1'b1;
        idx_o     = OW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - Z80 bus arbiter sharing the CPU bus among DMA requesters
//
// Purpose: requests the bus from the CPU on behalf of N_REQ DMA engines,
//          grants it round-robin, and returns it to the CPU for at least
//          CPU_GAP cycles between grants.
// Optional: define BUS_ARBITER_PARK_EN to hand the bus straight to the next
//          waiting requester (one dead cycle) instead of releasing to the CPU.
// Ports:
//   clk          in   1            system clock, rising edge
//   reset        in   1            synchronous, active-high
//   req_n        in   N_REQ        per-requester bus request, active low
//   gnt_n        out  N_REQ        per-requester grant, active low
//   cpu_busrq_n  out  1            Z80 BUSRQ, active low
//   cpu_busak_n  in   1            Z80 BUSAK, active low
//   owner        out  owner width  current or most recent grantee
//   busy         out  1            any grant active

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int CPU_GAP = DEF_CPU_GAP
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_n,
  output logic [N_REQ-1:0]          gnt_n,
  output logic                      cpu_busrq_n,
  input  logic                      cpu_busak_n,
  output logic [owner_w(N_REQ)-1:0] owner,
  output logic                      busy
);

  localparam int                   OW       = owner_w(N_REQ);
  localparam logic [OW-1:0]        LAST_IDX = OW'(N_REQ - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(CPU_GAP - 1);

  arb_state_e           state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic                 resume_q, resume_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;

  logic [N_REQ-1:0] req_act;
  logic [N_REQ-1:0] owner_mask;
  logic [OW-1:0]    pick_last;
  logic [OW-1:0]    pick_idx;
  logic             pick_valid;

  assign req_act    = ~req_n;
  assign owner_mask = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

  // After the CPU snatched the bus back mid-grant, start the search at the
  // interrupted owner itself so it is re-granted if still requesting.
  assign pick_last = !resume_q       ? owner_q  :
                     (owner_q == '0) ? LAST_IDX : owner_q - OW'(1);

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req_act),
    .last_i  (pick_last),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= LAST_IDX;
      resume_q <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      resume_q <= resume_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    resume_d    = resume_q;
    gap_d       = gap_q;
    cpu_busrq_n = !((state_q == ST_REQ) || (state_q == ST_GRANT));
    // Grants vanish combinationally the moment the CPU drops BUSAK.
    gnt_n       = ((state_q == ST_GRANT) && !cpu_busak_n) ? ~owner_mask : '1;

    case (state_q)
      ST_IDLE: begin
        if (|req_act) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!cpu_busak_n) begin
          resume_d = 1'b0;
          if (pick_valid) begin
            state_d = ST_GRANT;
            owner_d = pick_idx;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_GRANT: begin
        if (cpu_busak_n) begin
          state_d  = ST_REQ;
          resume_d = 1'b1;
        end else if ((req_act & owner_mask) == '0) begin
`ifdef BUS_ARBITER_PARK_EN
          // Passing through REQ gives the dead cycle and a fresh selection.
          state_d = (|(req_act & ~owner_mask)) ? ST_REQ : ST_RELEASE;
`else
          state_d = ST_RELEASE;
`endif
        end
      end
      ST_RELEASE: begin
        if (cpu_busak_n) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign owner = owner_q;
  assign busy  = ~&gnt_n;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter

module tb_bus_arbiter;

  localparam int N   = 4;
  localparam int GAP = 2;

  localparam int P_IDLE    = 0;
  localparam int P_REQ     = 1;
  localparam int P_GRANT   = 2;
  localparam int P_RELEASE = 3;
  localparam int P_GAP     = 4;

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic [3:0] req_n       = 4'hF;
  logic       cpu_busak_n = 1'b1;
  logic [3:0] gnt_n;
  logic       cpu_busrq_n;
  logic [1:0] owner;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int m_phase  = P_IDLE;
  int m_owner  = N - 1;
  int m_gap    = 0;
  int m_win    = 0;
  bit m_resume = 1'b0;
  bit m_valid  = 1'b0;

  int held[N];
  int lim[N];
  int order[5];
  int n_grants;
  logic [3:0] prev_gnt;

  bus_arbiter #(.N_REQ(N), .CPU_GAP(GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_n       (req_n),
    .gnt_n       (gnt_n),
    .cpu_busrq_n (cpu_busrq_n),
    .cpu_busak_n (cpu_busak_n),
    .owner       (owner),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic int rr_winner(input logic [3:0] rq_n, input int start);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (start + k) % N;
      if (!rq_n[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: bus ownership phases advanced from the sampled inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_phase  = P_IDLE;
      m_owner  = N - 1;
      m_gap    = 0;
      m_resume = 1'b0;
      m_valid  = 1'b1;
    end else begin
      case (m_phase)
        P_IDLE: if (req_n != 4'hF) m_phase = P_REQ;
        P_REQ: if (!cpu_busak_n) begin
          m_win    = rr_winner(req_n, m_resume ? m_owner : (m_owner + 1) % N);
          m_resume = 1'b0;
          if (m_win >= 0) begin
            m_owner = m_win;
            m_phase = P_GRANT;
          end else begin
            m_phase = P_RELEASE;
          end
        end
        P_GRANT: if (cpu_busak_n) begin
          m_phase  = P_REQ;
          m_resume = 1'b1;
        end else if (req_n[m_owner]) begin
`ifdef BUS_ARBITER_PARK_EN
          m_phase = (((~req_n) & ~(4'b0001 << m_owner)) != 4'b0000) ? P_REQ : P_RELEASE;
`else
          m_phase = P_RELEASE;
`endif
        end
        P_RELEASE: if (cpu_busak_n) begin
          m_phase = P_GAP;
          m_gap   = 0;
        end
        P_GAP: begin
          m_gap = m_gap + 1;
          if (m_gap == GAP) m_phase = P_IDLE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [3:0] eg;
    logic       eb;
    if (!m_valid) return;
    eb = !((m_phase == P_REQ) || (m_phase == P_GRANT));
    eg = ((m_phase == P_GRANT) && !cpu_busak_n) ? ~(4'b0001 << m_owner) : 4'hF;
    check("model_gnt_n", gnt_n, eg);
    check("model_busrq_n", cpu_busrq_n, eb);
    check("model_owner", owner, m_owner);
    check("model_busy", busy, eg != 4'hF);
    check("one_grant", $countones(~gnt_n) <= 1, 1);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    req_n = 4'hF;
    for (int c = 0; c < 12; c++) begin
      tick();
      cpu_busak_n = cpu_busrq_n;
    end
  endtask

  task automatic wait_grant(input logic [3:0] pat, input string name);
    bit found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (gnt_n == pat) found = 1'b1;
      else cpu_busak_n = cpu_busrq_n;
    end
    check(name, found, 1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    #1;
    check("rst_gnt_n", gnt_n, 4'hF);
    check("rst_busrq_n", cpu_busrq_n, 1);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 3);
    reset = 1'b0;
    tick();

    // Requester 0 alone, CPU acks three cycles after the request
    req_n = 4'b1110;
    tick(); #1;
    check("s1_busrq_low", cpu_busrq_n, 0);
    check("s1_no_gnt_yet", gnt_n, 4'hF);
    tick();
    tick();
    cpu_busak_n = 1'b0;
    #1;
    check("s1_gnt_before_ack", gnt_n, 4'hF);
    tick(); #1;
    check("s1_gnt", gnt_n, 4'b1110);
    check("s1_owner", owner, 0);
    check("s1_busy", busy, 1);
    check("s1_model_owner", m_owner, 0);

    // Requesters 0 and 2; owner 0 then releases
    req_n = 4'b1010;
    tick(); #1;
    check("s2_still_granted", gnt_n, 4'b1110);
    req_n = 4'b1011;
    tick(); #1;
`ifdef BUS_ARBITER_PARK_EN
    check("s3_busrq_held", cpu_busrq_n, 0);
    check("s3_dead_cycle", gnt_n, 4'hF);
    tick(); #1;
    check("s3_gnt2", gnt_n, 4'b1011);
    check("s3_busrq_still_low", cpu_busrq_n, 0);
    check("s3_owner", owner, 2);
`else
    check("s2_busrq_high", cpu_busrq_n, 1);
    check("s2_gnt_off", gnt_n, 4'hF);
    cpu_busak_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      check("s2_busrq_gap", cpu_busrq_n, 1);
    end
    tick(); #1;
    check("s2_rerequest", cpu_busrq_n, 0);
    cpu_busak_n = 1'b0;
    tick(); #1;
    check("s2_gnt2", gnt_n, 4'b1011);
    check("s2_owner", owner, 2);
`endif
    drain();

    // All four requesting, each holding its grant for 5 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_n = 4'h0;
    cpu_busak_n = 1'b1;
    n_grants = 0;
    prev_gnt = 4'hF;
    for (int i = 0; i < N; i++) held[i] = 0;
    for (int c = 0; c < 300 && n_grants < 5; c++) begin
      tick();
      if (gnt_n != 4'hF && gnt_n != prev_gnt) begin
        for (int i = 0; i < N; i++) if (!gnt_n[i]) order[n_grants] = i;
        n_grants++;
      end
      prev_gnt = gnt_n;
      for (int i = 0; i < N; i++) begin
        if (req_n[i]) begin
          req_n[i] = 1'b0;
        end else if (!gnt_n[i]) begin
          held[i]++;
          if (held[i] == 5) begin
            req_n[i] = 1'b1;
            held[i]  = 0;
          end
        end
      end
      cpu_busak_n = cpu_busrq_n;
    end
    check("s4_grant_count", n_grants, 5);
    for (int k = 0; k < 5; k++) check("s4_order", order[k], k % 4);
    drain();

    // Reset while requester 2 holds the bus
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_busak_n = 1'b1;
    req_n = 4'b1011;
    wait_grant(4'b1011, "s5_reach_grant");
    reset = 1'b1;
    tick(); #1;
    check("s5_gnt_off", gnt_n, 4'hF);
    check("s5_busrq_n", cpu_busrq_n, 1);
    check("s5_owner", owner, 3);
    check("s5_busy", busy, 0);
    reset = 1'b0;
    tick(); #1;
    check("s5_idle_to_req", cpu_busrq_n, 0);
    drain();

    // CPU drops BUSAK mid-grant; owner 0 is re-granted ahead of waiting 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_busak_n = 1'b1;
    req_n = 4'b1100;
    wait_grant(4'b1110, "s6_reach_grant");
    cpu_busak_n = 1'b1;
    #1;
    check("s6_gnt_forced_high", gnt_n, 4'hF);
    check("s6_busy_low", busy, 0);
    tick(); #1;
    check("s6_busrq_held", cpu_busrq_n, 0);
    check("s6_gnt_still_off", gnt_n, 4'hF);
    cpu_busak_n = 1'b0;
    tick(); #1;
    check("s6_regrant", gnt_n, 4'b1110);
    check("s6_owner", owner, 0);
    drain();

    // Randomized traffic against the model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_busak_n = 1'b1;
    req_n = 4'hF;
    for (int i = 0; i < N; i++) begin
      held[i] = 0;
      lim[i]  = 1;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (req_n[i]) begin
          held[i] = 0;
          if ($urandom_range(0, 7) == 0) req_n[i] = 1'b0;
        end else if (!gnt_n[i]) begin
          if (held[i] == 0) lim[i] = $urandom_range(1, 6);
          held[i]++;
          if (held[i] >= lim[i]) req_n[i] = 1'b1;
        end else if ($urandom_range(0, 40) == 0) begin
          req_n[i] = 1'b1;
        end
      end
      if (!cpu_busrq_n && cpu_busak_n) begin
        if ($urandom_range(0, 2) == 0) cpu_busak_n = 1'b0;
      end else if (cpu_busrq_n && !cpu_busak_n) begin
        if ($urandom_range(0, 1) == 0) cpu_busak_n = 1'b1;
      end else if (!cpu_busrq_n && !cpu_busak_n) begin
        if ($urandom_range(0, 60) == 0) cpu_busak_n = 1'b1;
      end
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of DMA requesters (2..8).
REQ-002 SHALL have parameter CPU_GAP, default 2, minimum number of cycles the bus returns to the CPU between grants (1..15).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_n  input  N_REQ  per-requester bus request, active low (driven by each simpledma busrq_n).
REQ-006 SHALL have port gnt_n  output  N_REQ  per-requester grant, active low (drives each DMA busak_n).
REQ-007 SHALL have port cpu_busrq_n  output  1  Z80 BUSRQ, active low.
REQ-008 SHALL have port cpu_busak_n  input  1  Z80 BUSAK, active low.
REQ-009 SHALL have port owner  output  clog2(N_REQ)  index of the current or most recent grantee.
REQ-010 SHALL have port busy  output  1  high while any gnt_n bit is low.

Function
REQ-011 SHALL implement states IDLE, REQ, GRANT, RELEASE, GAP.
REQ-012 IDLE: on any req_n bit low -> REQ, cpu_busrq_n low from the next cycle.
REQ-013 REQ: on cpu_busak_n low -> pick the winner and enter GRANT, with the winner's gnt_n low the following cycle.
REQ-014 Winner selection SHALL be round-robin: the first active requester strictly after the last owner, wrapping N_REQ-1 -> 0, sampled in the selecting cycle.
REQ-015 At most one gnt_n bit SHALL be low in any cycle.
REQ-016 GRANT SHALL hold until the owner's req_n is high; there is no preemption and no hold limit.
REQ-017 The owner's gnt_n SHALL go high the cycle after its req_n is sampled high.
REQ-018 RELEASE: cpu_busrq_n high; wait for cpu_busak_n high, then go to GAP.
REQ-019 GAP: count CPU_GAP cycles with cpu_busrq_n high, then go to IDLE.
REQ-020 gnt_n SHALL be forced high combinationally whenever cpu_busak_n is high. If cpu_busak_n rises during GRANT, the state SHALL go to REQ with cpu_busrq_n still low, and the owner SHALL be retained.
REQ-021 A requester that releases during REQ before any grant SHALL be ignored; if no request remains at selection time -> RELEASE.
REQ-022 owner SHALL update only when a grant is issued; busy = ~&gnt_n.

Reset
REQ-023 When reset is high at a clock edge: state IDLE; gnt_n all ones; cpu_busrq_n 1; busy 0; owner N_REQ-1, so requester 0 wins first; GAP counter 0.
REQ-024 Reset SHALL take effect mid-grant without any drain. The DMA sees its grant removed on the next cycle.

Configuration
REQ-025 Macro BUS_ARBITER_PARK_EN:
- Defined: at owner release, if another req_n is low and cpu_busak_n is low, hand the bus over directly. One dead cycle with all gnt_n high, then the new winner is granted. cpu_busrq_n stays low; RELEASE and GAP are skipped.
- Undefined: every grant ends via RELEASE and GAP.

Structure
REQ-026 A shared package bus_arbiter_pkg SHALL hold the state enum, the default N_REQ and CPU_GAP constants, and the owner-width function.
REQ-027 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, last owner; outputs: valid, index).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- req_n=4'b1110, CPU acks 3 cycles later -> cpu_busrq_n low the cycle after the request; gnt_n=4'b1110 one cycle after ack; owner=0.
- req_n=4'b1010, then owner 0 releases, PARK undefined -> cpu_busrq_n high, then after busak high 2 gap cycles, re-request; grant to 2 (gnt_n=4'b1011).
- Same stimulus, PARK defined -> cpu_busrq_n stays low; gnt_n 4'b1111 for exactly 1 cycle, then 4'b1011.
- All four requesting continuously, each releasing after 5 cycles -> grant order 0,1,2,3,0; never two gnt_n bits low.
- reset pulsed during GRANT to owner 2 -> next cycle gnt_n=4'b1111, cpu_busrq_n=1, owner=3, state IDLE.
- cpu_busak_n driven high mid-GRANT -> gnt_n all high in the same cycle; regrant to the same owner when cpu_busak_n returns low.
